// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types for the two-master Wishbone arbiter.
//   state_t         arbiter grant state
//   gnt_idx_t       index of a master (0 or 1)
//   DEFAULT_TIMEOUT watchdog limit used when the top is not overridden
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   typedef logic gnt_idx_t;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb2_if.sv
// wb_arb2_if: one Wishbone classic link (single held-strobe transfers).
//   cyc, stb, we, adr, sel, dat_w   initiator -> target
//   dat_r, ack, err, rty, stall     target -> initiator
// Modports:
//   master  the initiating side (drives cyc/stb/...)
//   slave   the responding side (drives ack/err/rty/stall/dat_r)
interface wb_arb2_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [ADDR_WIDTH-1:0] adr;
   logic [3:0]            sel;
   logic [31:0]           dat_w;
   logic [31:0]           dat_r;
   logic                  ack;
   logic                  err;
   logic                  rty;
   logic                  stall;

   modport master (
      output cyc, stb, we, adr, sel, dat_w,
      input  dat_r, ack, err, rty, stall
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_w,
      output dat_r, ack, err, rty, stall
   );
endinterface

// File: rtl/wb_arb_wdog.sv
// wb_arb_wdog: grant watchdog counter for wb_arb2.
// Only instantiated when WB_ARB2_TIMEOUT_EN is defined.
//   clk_i, rst_i  clock, async active-high reset
//   load          clear the count (outside a grant / on grant release)
//   en            count one granted cycle without termination
//   expire        count has reached TIMEOUT_CYCLES-1
module wb_arb_wdog
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     cnt <= '0;
      else if (load) cnt <= '0;
      else if (en)   cnt <= cnt + CW'(1);
   end

   assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master round-robin Wishbone arbiter onto one slave port.
//   clk_i  clock, rising edge
//   rst_i  async active-high reset
//   m0, m1 master-facing links (slave modport): requests in, responses out
//   s      slave-facing link (master modport): muxed request out
// Optional WB_ARB2_TIMEOUT_EN: a watchdog errors the granted master and
// releases the grant after TIMEOUT_CYCLES granted cycles with no response.
//
// state | meaning
// IDLE  | no grant; slave outputs all zero
// GNT0  | master 0 owns the slave port
// GNT1  | master 1 owns the slave port
module wb_arb2
   import wb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input logic       clk_i,
   input logic       rst_i,
   wb_arb2_if.slave  m0,
   wb_arb2_if.slave  m1,
   wb_arb2_if.master s
);

   state_t   state, state_nxt;
   gnt_idx_t last, last_nxt;

   logic     req0, req1;
   logic     in_gnt;
   gnt_idx_t g_sel;
   logic     g_cyc;
   logic     gnt0, gnt1;
   logic     s_term, term, rel;
   logic     wd_expire;

   assign req0   = m0.cyc & m0.stb;
   assign req1   = m1.cyc & m1.stb;
   assign in_gnt = (state != IDLE);
   assign g_sel  = gnt_idx_t'(state == GNT1);
   assign g_cyc  = g_sel ? m1.cyc : m0.cyc;

   // Grant is only "live" while the owner still drives cyc&stb, so a
   // response arriving in an abort cycle is not routed back.
   assign gnt0   = (state == GNT0) & req0;
   assign gnt1   = (state == GNT1) & req1;

   assign s_term = s.ack | s.err | s.rty;
   assign term   = s_term | wd_expire;
   assign rel    = in_gnt & (term | ~g_cyc);

`ifdef WB_ARB2_TIMEOUT_EN
   logic wd_load, wd_en, wd_cnt_done;

   assign wd_load = ~in_gnt | rel;
   assign wd_en   = in_gnt & ~term;

   wb_arb_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load   (wd_load),
      .en     (wd_en),
      .expire (wd_cnt_done)
   );

   assign wd_expire = in_gnt & wd_cnt_done;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      s.cyc     = 1'b0;
      s.stb     = 1'b0;
      s.we      = 1'b0;
      s.adr     = '0;
      s.sel     = '0;
      s.dat_w   = '0;

      unique case (state)
         IDLE: begin
            if (req0 & req1)  state_nxt = last ? GNT0 : GNT1;
            else if (req0)    state_nxt = GNT0;
            else if (req1)    state_nxt = GNT1;
         end
         GNT0: begin
            if (rel) begin
               last_nxt  = 1'b0;
               state_nxt = req1 ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (rel) begin
               last_nxt  = 1'b1;
               state_nxt = req0 ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (in_gnt) begin
         s.cyc   = (gnt0 | gnt1) & ~wd_expire;
         s.stb   = (gnt0 | gnt1) & ~wd_expire;
         s.we    = g_sel ? m1.we    : m0.we;
         s.adr   = g_sel ? m1.adr   : m0.adr;
         s.sel   = g_sel ? m1.sel   : m0.sel;
         s.dat_w = g_sel ? m1.dat_w : m0.dat_w;
      end
   end

   assign m0.ack   = s.ack & gnt0;
   assign m0.err   = (s.err | wd_expire) & gnt0;
   assign m0.rty   = s.rty & gnt0;
   assign m0.stall = req0 & ~(gnt0 & term);
   assign m0.dat_r = s.dat_r;

   assign m1.ack   = s.ack & gnt1;
   assign m1.err   = (s.err | wd_expire) & gnt1;
   assign m1.rty   = s.rty & gnt1;
   assign m1.stall = req1 & ~(gnt1 & term);
   assign m1.dat_r = s.dat_r;

   // Slave stall only delays the slave; the owner keeps stb held meanwhile.
   logic unused_stall;
   assign unused_stall = s.stall;

endmodule

// File: tb/tb_wb_arb2.sv
module tb_wb_arb2;

`ifdef WB_ARB2_TIMEOUT_EN
   localparam int TO    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_arb2_if #(.ADDR_WIDTH(32)) m0_bus ();
   wb_arb2_if #(.ADDR_WIDTH(32)) m1_bus ();
   wb_arb2_if #(.ADDR_WIDTH(32)) s_bus ();

   logic        man_ack = 1'b0, man_err = 1'b0, man_rty = 1'b0;
   logic        man_stall = 1'b0, auto_ack = 1'b0;
   logic [31:0] sdat = 32'h0;

   assign s_bus.ack   = man_ack | (auto_ack & s_bus.stb);
   assign s_bus.err   = man_err;
   assign s_bus.rty   = man_rty;
   assign s_bus.stall = man_stall;
   assign s_bus.dat_r = sdat;

   wb_arb2 #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .m0    (m0_bus),
      .m1    (m1_bus),
      .s     (s_bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic drive_m(input int k, input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      if (k == 0) begin
         m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
         m0_bus.adr = adr; m0_bus.sel = sel; m0_bus.dat_w = dat;
      end else begin
         m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
         m1_bus.adr = adr; m1_bus.sel = sel; m1_bus.dat_w = dat;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   // Behavioural model: owner of the slave port (-1 none), last served, granted-cycle age
   int owner = -1, last_m = 1, age = 0;
   int n_owner = -1, n_last = 1, n_age = 0;

   logic        rq[2], cy[2], we_a[2];
   logic [31:0] adr_a[2], dat_a[2];
   logic [3:0]  sel_a[2];
   logic        e_ack[2], e_err[2], e_rty[2], e_stall[2];
   logic        e_scyc, e_we;
   logic [31:0] e_adr, e_dat;
   logic [3:0]  e_sel;
   logic        expire, term;
   int          g;

   always @(negedge clk) begin
      if (rst) begin owner = -1; last_m = 1; age = 0; end
      cy[0] = m0_bus.cyc; rq[0] = m0_bus.cyc & m0_bus.stb; we_a[0] = m0_bus.we;
      adr_a[0] = m0_bus.adr; sel_a[0] = m0_bus.sel; dat_a[0] = m0_bus.dat_w;
      cy[1] = m1_bus.cyc; rq[1] = m1_bus.cyc & m1_bus.stb; we_a[1] = m1_bus.we;
      adr_a[1] = m1_bus.adr; sel_a[1] = m1_bus.sel; dat_a[1] = m1_bus.dat_w;

      e_scyc = 0; e_we = 0; e_adr = 0; e_sel = 0; e_dat = 0;
      for (int k = 0; k < 2; k++) begin
         e_ack[k] = 0; e_err[k] = 0; e_rty[k] = 0; e_stall[k] = rq[k];
      end

      if (owner >= 0) begin
         g      = owner;
         expire = TO_EN && (age == TO - 1);
         term   = s_bus.ack | s_bus.err | s_bus.rty | expire;
         e_scyc = rq[g] & ~expire;
         e_we   = we_a[g]; e_adr = adr_a[g]; e_sel = sel_a[g]; e_dat = dat_a[g];
         e_ack[g]   = s_bus.ack & rq[g];
         e_err[g]   = (s_bus.err | expire) & rq[g];
         e_rty[g]   = s_bus.rty & rq[g];
         e_stall[g] = rq[g] & ~term;
         if (term || !cy[g]) begin
            n_last  = g;
            n_owner = rq[1-g] ? 1 - g : -1;
            n_age   = 0;
         end else begin
            n_last = last_m; n_owner = g; n_age = age + 1;
         end
      end else begin
         n_age  = 0;
         n_last = last_m;
         if (rq[0] && rq[1]) n_owner = (last_m == 1) ? 0 : 1;
         else if (rq[0])     n_owner = 0;
         else if (rq[1])     n_owner = 1;
         else                n_owner = -1;
      end
      if (rst) begin n_owner = -1; n_last = 1; n_age = 0; end

      chk("s_cyc", s_bus.cyc, e_scyc);
      chk("s_stb", s_bus.stb, e_scyc);
      chk("s_we",  s_bus.we,  e_we);
      chk("s_adr", s_bus.adr, e_adr);
      chk("s_sel", s_bus.sel, e_sel);
      chk("s_dat", s_bus.dat_w, e_dat);
      chk("m0_ack", m0_bus.ack, e_ack[0]);
      chk("m0_err", m0_bus.err, e_err[0]);
      chk("m0_rty", m0_bus.rty, e_rty[0]);
      chk("m0_stall", m0_bus.stall, e_stall[0]);
      chk("m0_dat", m0_bus.dat_r, sdat);
      chk("m1_ack", m1_bus.ack, e_ack[1]);
      chk("m1_err", m1_bus.err, e_err[1]);
      chk("m1_rty", m1_bus.rty, e_rty[1]);
      chk("m1_stall", m1_bus.stall, e_stall[1]);
      chk("m1_dat", m1_bus.dat_r, sdat);
   end

   always @(posedge clk) begin
      if (rst) begin owner = -1; last_m = 1; age = 0; end
      else begin owner = n_owner; last_m = n_last; age = n_age; end
   end

   int exp_order[4] = '{0, 1, 0, 1};
   int got;

   initial begin
      drive_m(0, 0, 0, 0, 0, 0, 0);
      drive_m(1, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      settle;
      chk("rst_s_cyc", s_bus.cyc, 0);
      chk("rst_s_adr", s_bus.adr, 0);
      chk("rst_m0_stall", m0_bus.stall, 0);
      chk("rst_m1_ack", m1_bus.ack, 0);

      // single m0 read
      tick; drive_m(0, 1, 1, 0, 32'h10, 4'hF, 0); sdat = 32'hDEADBEEF; settle;
      chk("t1_idle_cyc", s_bus.cyc, 0);
      chk("t1_idle_stall", m0_bus.stall, 1);
      tick; settle;
      chk("t1_cyc_n1", s_bus.cyc, 1);
      chk("t1_adr", s_bus.adr, 32'h10);
      chk("t1_no_ack_yet", m0_bus.ack, 0);
      tick; man_ack = 1; settle;
      chk("t1_m0_ack", m0_bus.ack, 1);
      chk("t1_m0_dat", m0_bus.dat_r, 32'hDEADBEEF);
      chk("t1_m1_quiet", {m1_bus.ack, m1_bus.err, m1_bus.rty, m1_bus.stall}, 4'b0000);
      tick; man_ack = 0; drive_m(0, 0, 0, 0, 0, 0, 0); settle;
      chk("t1_release", s_bus.cyc, 0);

      // async reset mid-transfer
      tick; drive_m(1, 1, 1, 0, 32'h20, 4'hF, 0);
      tick; settle;
      chk("t5_cyc", s_bus.cyc, 1);
      #1 rst = 1'b1;
      #1 chk("t5_async_drop", s_bus.cyc, 0);
      chk("t5_no_resp", m1_bus.ack, 0);
      tick; drive_m(1, 0, 0, 0, 0, 0, 0);
      tick; rst = 1'b0;

      // contention, 1-cycle slave
      tick;
      drive_m(0, 1, 1, 0, 32'h100, 4'hF, 0);
      drive_m(1, 1, 1, 0, 32'h200, 4'hF, 0);
      auto_ack = 1; sdat = 32'h12345678; settle;
      chk("t2_idle_cyc", s_bus.cyc, 0);
      for (int i = 0; i < 4; i++) begin
         tick; settle;
         got = m0_bus.ack ? 0 : (m1_bus.ack ? 1 : 9);
         chk($sformatf("t2_order%0d", i), got, exp_order[i]);
         chk("t2_no_idle", s_bus.cyc, 1);
         if (exp_order[i] == 0) chk("t2_m1_waits", m1_bus.stall, 1);
         else                   chk("t2_m0_waits", m0_bus.stall, 1);
      end
      tick; auto_ack = 0;
      drive_m(0, 0, 0, 0, 0, 0, 0);
      drive_m(1, 0, 0, 0, 0, 0, 0); settle;
      chk("t2_drop", s_bus.cyc, 0);
      tick;

      // m1 write with slave stall
      drive_m(1, 1, 1, 1, 32'h300, 4'b0011, 32'hA5A5A5A5); man_stall = 1; settle;
      chk("t3_idle_cyc", s_bus.cyc, 0);
      for (int i = 0; i < 3; i++) begin
         tick; settle;
         chk("t3_cyc", s_bus.cyc, 1);
         chk("t3_dat", s_bus.dat_w, 32'hA5A5A5A5);
         chk("t3_sel", s_bus.sel, 4'b0011);
         chk("t3_we", s_bus.we, 1);
         chk("t3_no_ack", m1_bus.ack, 0);
         chk("t3_stall", m1_bus.stall, 1);
      end
      tick; man_stall = 0; man_ack = 1; settle;
      chk("t3_ack", m1_bus.ack, 1);
      chk("t3_stall_clr", m1_bus.stall, 0);
      tick; man_ack = 0; drive_m(1, 0, 0, 0, 0, 0, 0); settle;
      chk("t3_release", s_bus.cyc, 0);

      // abort with a late ack
      tick; drive_m(0, 1, 1, 0, 32'h400, 4'hF, 0);
      tick; settle;
      chk("t4_cyc", s_bus.cyc, 1);
      tick; drive_m(0, 0, 0, 0, 32'h400, 4'hF, 0); man_ack = 1; settle;
      chk("t4_cyc_gated", s_bus.cyc, 0);
      chk("t4_no_ack", m0_bus.ack, 0);
      tick; man_ack = 0; drive_m(0, 1, 1, 0, 32'h404, 4'hF, 0); settle;
      chk("t4_idle_after", s_bus.cyc, 0);
      tick; settle;
      chk("t4_regrant", s_bus.cyc, 1);
      tick; man_ack = 1; settle;
      chk("t4_ack", m0_bus.ack, 1);
      tick; man_ack = 0; drive_m(0, 0, 0, 0, 0, 0, 0);

      // hung slave
      tick; drive_m(0, 1, 1, 0, 32'h500, 4'hF, 0);
      tick; drive_m(1, 1, 1, 0, 32'h600, 4'hF, 0); settle;
      chk("t6_adr0", s_bus.adr, 32'h500);
      chk("t6_err_c1", m0_bus.err, 0);
`ifdef WB_ARB2_TIMEOUT_EN
      for (int c = 2; c <= 4; c++) begin
         tick; settle;
         if (c < 4) begin
            chk("t6_err_early", m0_bus.err, 0);
            chk("t6_cyc_held", s_bus.cyc, 1);
         end else begin
            chk("t6_err_pulse", m0_bus.err, 1);
            chk("t6_cyc_forced", s_bus.cyc, 0);
         end
      end
      tick; drive_m(0, 0, 0, 0, 0, 0, 0); settle;
      chk("t6_m1_cyc", s_bus.cyc, 1);
      chk("t6_m1_adr", s_bus.adr, 32'h600);
      chk("t6_err_gone", m0_bus.err, 0);
`else
      for (int c = 2; c <= 100; c++) begin
         tick; settle;
         chk("t6_no_err", m0_bus.err, 0);
         chk("t6_held", s_bus.cyc, 1);
      end
      tick; drive_m(0, 0, 0, 0, 0, 0, 0); settle;
      chk("t6_abort", s_bus.cyc, 0);
      tick; settle;
      chk("t6_m1_cyc", s_bus.cyc, 1);
      chk("t6_m1_adr", s_bus.adr, 32'h600);
`endif
      tick; man_ack = 1; settle;
      chk("t6_m1_ack", m1_bus.ack, 1);
      tick; man_ack = 0; drive_m(1, 0, 0, 0, 0, 0, 0);
      repeat (3) tick;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
